// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide, one bit per cycle, start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  eq
);

    localparam int                   c_cnt_w   = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0]   c_last    = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] c_ones   = '1;
    localparam logic [DATA_WIDTH-1:0] c_min    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [1:0]           c_st_idle = 2'd0;
    localparam logic [1:0]           c_st_run  = 2'd1;
    localparam logic [1:0]           c_st_done = 2'd2;

    logic [1:0]              r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_opd;
    logic [2:0]              r_op;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic                    r_spec;

    // Operand decode on the accept edge
    logic                  w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag, w_b_mag, w_spec_res;
    logic                  w_div_zero, w_ovf, w_special;

    assign w_a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    assign w_b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign w_a_neg    = w_a_signed & in1[DATA_WIDTH-1];
    assign w_b_neg    = w_b_signed & in2[DATA_WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~in1 + 1'b1) : in1;
    assign w_b_mag    = w_b_neg ? (~in2 + 1'b1) : in2;
    assign w_div_zero = op[2] & (in2 == '0);
    assign w_ovf      = op[2] & ~op[0] & (in1 == c_min) & (in2 == c_ones);
    assign w_special  = w_div_zero | w_ovf;
    assign w_spec_res = w_div_zero ? (op[1] ? in1 : c_ones)
                                   : (op[1] ? '0 : in1);

    // One iteration of either datapath; r_acc = {high/remainder, low/quotient}
    logic [DATA_WIDTH:0]     w_mul_sum, w_partial, w_diff;
    logic [2*DATA_WIDTH-1:0] w_mul_next, w_div_next, w_acc_next, w_prod;
    logic [DATA_WIDTH-1:0]   w_quo, w_rem, w_final;

    assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};
    assign w_partial  = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
    assign w_diff     = w_partial - {1'b0, r_opd};
    assign w_div_next = w_diff[DATA_WIDTH]
                      ? {w_partial[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0}
                      : {w_diff[DATA_WIDTH-1:0],    r_acc[DATA_WIDTH-2:0], 1'b1};
    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod     = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quo      = w_acc_next[DATA_WIDTH-1:0];
    assign w_rem      = w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        w_final = '0;
        if (r_spec)
            w_final = r_acc[DATA_WIDTH-1:0];
        else if (!r_op[2])
            w_final = (r_op[1:0] == 2'b00) ? w_prod[DATA_WIDTH-1:0]
                                           : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        else if (r_op[1])
            w_final = r_neg_r ? (~w_rem + 1'b1) : w_rem;
        else
            w_final = r_neg_q ? (~w_quo + 1'b1) : w_quo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_op     <= 3'b000;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_spec   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_run: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state  <= c_st_done;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                    end
                end
                default: begin
                    // The done cycle doubles as an issue slot, giving W+1 throughput
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_opd   <= op[2] ? w_b_mag : w_a_mag;
                        r_acc   <= {{DATA_WIDTH{1'b0}},
                                    w_special ? w_spec_res : (op[2] ? w_a_mag : w_b_mag)};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_spec  <= w_special;
                        if (w_special && r_state == c_st_idle) begin
                            r_state  <= c_st_done;
                            r_done   <= 1'b1;
                            r_result <= w_spec_res;
                        end else begin
                            // A special issued from the done cycle takes one RUN
                            // cycle so done never stays high two cycles in a row
                            r_state <= c_st_run;
                            r_cnt   <= w_special ? c_last : '0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign eq     = (r_result == '0);

endmodule
`default_nettype wire
